// File: rtl/div_sequencer.sv
// div_sequencer: multi-cycle restoring radix-2 divide controller (DIV/DIVU/REM/REMU).
// Optional last-result cache enabled with `define DIV_RESULT_CACHE_EN.
module div_sequencer #(
   parameter int WIDTH = 32
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             START,
   input  logic             FLUSH,
   input  logic [1:0]       DIV_OP,
   input  logic [WIDTH-1:0] DATA1,
   input  logic [WIDTH-1:0] DATA2,
   output logic [WIDTH-1:0] RESULT,
   output logic             DONE,
   output logic             BUSY,
   output logic             STALL
);

   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
   localparam logic [CW-1:0] CNT_MAX  = CW'(WIDTH);
   localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH-1:0] dvs_q, dvs_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             q_neg_q, q_neg_d;
   logic             r_neg_q, r_neg_d;
   logic             sel_r_q, sel_r_d;
   logic             busy_q, busy_d;

   logic             sgn, s1, s2;
   logic [WIDTH-1:0] abs1, abs2;
   logic             div_zero, ovf;
   logic [WIDTH:0]   rem_sh, diff;
   logic             no_borrow;
   logic [WIDTH-1:0] rem_nx, quo_nx, q_fix, r_fix;
   logic             hit;
   logic [WIDTH-1:0] hit_res;

   assign sgn      = ~DIV_OP[0];
   assign s1       = sgn & DATA1[WIDTH-1];
   assign s2       = sgn & DATA2[WIDTH-1];
   assign abs1     = s1 ? -DATA1 : DATA1;
   assign abs2     = s2 ? -DATA2 : DATA2;
   assign div_zero = (DATA2 == '0);
   assign ovf      = sgn & (DATA1 == MIN) & (DATA2 == '1);

   assign rem_sh    = {rem_q, quo_q[WIDTH-1]};
   assign diff      = rem_sh - {1'b0, dvs_q};
   assign no_borrow = ~diff[WIDTH];
   assign rem_nx    = no_borrow ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
   assign quo_nx    = {quo_q[WIDTH-2:0], no_borrow};
   assign q_fix     = q_neg_q ? -quo_nx : quo_nx;
   assign r_fix     = r_neg_q ? -rem_nx : rem_nx;

`ifdef DIV_RESULT_CACHE_EN
   logic             c_vld_q, c_vld_d;
   logic             c_sgn_q, c_sgn_d;
   logic [WIDTH-1:0] c_a_q, c_a_d, c_b_q, c_b_d;
   logic [WIDTH-1:0] c_qt_q, c_qt_d, c_rm_q, c_rm_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
   logic             sgn_q, sgn_d;

   assign hit = c_vld_q & (c_a_q == DATA1) & (c_b_q == DATA2)
              & (c_sgn_q == sgn);
   assign hit_res = DIV_OP[1] ? c_rm_q : c_qt_q;
`else
   assign hit     = 1'b0;
   assign hit_res = '0;
`endif

   // Next-state, datapath iteration, special cases and result selection
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      rem_d    = rem_q;
      quo_d    = quo_q;
      dvs_d    = dvs_q;
      result_d = result_q;
      q_neg_d  = q_neg_q;
      r_neg_d  = r_neg_q;
      sel_r_d  = sel_r_q;
      busy_d   = 1'b0;
`ifdef DIV_RESULT_CACHE_EN
      c_vld_d  = c_vld_q;
      c_sgn_d  = c_sgn_q;
      c_a_d    = c_a_q;
      c_b_d    = c_b_q;
      c_qt_d   = c_qt_q;
      c_rm_d   = c_rm_q;
      a_d      = a_q;
      b_d      = b_q;
      sgn_d    = sgn_q;
`endif
      case (state_q)
         S_RUN: begin
            rem_d = rem_nx;
            quo_d = quo_nx;
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
               state_d  = S_DONE;
               result_d = sel_r_q ? r_fix : q_fix;
`ifdef DIV_RESULT_CACHE_EN
               if (!FLUSH) begin
                  c_vld_d = 1'b1;
                  c_sgn_d = sgn_q;
                  c_a_d   = a_q;
                  c_b_d   = b_q;
                  c_qt_d  = q_fix;
                  c_rm_d  = r_fix;
               end
`endif
            end else begin
               busy_d = 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
            if (START) begin
               if (div_zero) begin
                  state_d  = S_DONE;
                  result_d = DIV_OP[1] ? DATA1 : '1;
               end else if (ovf) begin
                  state_d  = S_DONE;
                  result_d = DIV_OP[1] ? '0 : MIN;
               end else if (hit) begin
                  state_d  = S_DONE;
                  result_d = hit_res;
               end else begin
                  state_d = S_RUN;
                  busy_d  = 1'b1;
                  cnt_d   = '0;
                  rem_d   = '0;
                  quo_d   = abs1;
                  dvs_d   = abs2;
                  q_neg_d = s1 ^ s2;
                  r_neg_d = s1;
                  sel_r_d = DIV_OP[1];
`ifdef DIV_RESULT_CACHE_EN
                  a_d     = DATA1;
                  b_d     = DATA2;
                  sgn_d   = sgn;
`endif
               end
            end
         end
      endcase
      if (FLUSH) begin
         state_d  = S_IDLE;
         busy_d   = 1'b0;
         result_d = result_q;
      end
   end

   // Control and datapath registers
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         rem_q    <= '0;
         quo_q    <= '0;
         dvs_q    <= '0;
         result_q <= '0;
         q_neg_q  <= 1'b0;
         r_neg_q  <= 1'b0;
         sel_r_q  <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         rem_q    <= rem_d;
         quo_q    <= quo_d;
         dvs_q    <= dvs_d;
         result_q <= result_d;
         q_neg_q  <= q_neg_d;
         r_neg_q  <= r_neg_d;
         sel_r_q  <= sel_r_d;
         busy_q   <= busy_d;
      end
   end

`ifdef DIV_RESULT_CACHE_EN
   // Last-result cache and the operands of the op in flight
   always_ff @(posedge CLK) begin
      if (RESET) begin
         c_vld_q <= 1'b0;
         c_sgn_q <= 1'b0;
         c_a_q   <= '0;
         c_b_q   <= '0;
         c_qt_q  <= '0;
         c_rm_q  <= '0;
         a_q     <= '0;
         b_q     <= '0;
         sgn_q   <= 1'b0;
      end else begin
         c_vld_q <= c_vld_d;
         c_sgn_q <= c_sgn_d;
         c_a_q   <= c_a_d;
         c_b_q   <= c_b_d;
         c_qt_q  <= c_qt_d;
         c_rm_q  <= c_rm_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sgn_q   <= sgn_d;
      end
   end
`endif

   assign RESULT = result_q;
   assign DONE   = (state_q == S_DONE);
   assign BUSY   = busy_q;
   assign STALL  = ~RESET & ((START & ((state_q == S_IDLE) | (state_q == S_DONE)))
                            | (state_q == S_RUN));

endmodule

// File: tb/tb_div_sequencer.sv
// tb_div_sequencer: scoreboard bench for div_sequencer with directed vectors.
// Expected results and DONE cycles are queued at issue time and checked by a monitor.
module tb_div_sequencer;

   logic        CLK = 1'b0;
   logic        RESET, START, FLUSH;
   logic [1:0]  DIV_OP;
   logic [31:0] DATA1, DATA2, RESULT;
   logic        DONE, BUSY, STALL;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   typedef struct {
      logic [31:0] res;
      int          at;
      string       nm;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;

`ifdef DIV_RESULT_CACHE_EN
   localparam bit CACHE = 1'b1;
`else
   localparam bit CACHE = 1'b0;
`endif
   bit          mvld = 1'b0;
   bit          msgn;
   logic [31:0] ma, mb;

   div_sequencer #(.WIDTH(32)) dut (
      .CLK(CLK), .RESET(RESET), .START(START), .FLUSH(FLUSH),
      .DIV_OP(DIV_OP), .DATA1(DATA1), .DATA2(DATA2),
      .RESULT(RESULT), .DONE(DONE), .BUSY(BUSY), .STALL(STALL)
   );

   always #5 CLK = ~CLK;

   always @(posedge CLK) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   always @(negedge CLK) begin
      if (!RESET && DONE) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL spurious_done actual=DONE expected=no DONE (cycle %0d)", cyc);
         end else begin
            mon_e = sb.pop_front();
            chk({mon_e.nm, "_result"}, RESULT, mon_e.res);
            chk({mon_e.nm, "_done_cycle"}, 32'(cyc), 32'(mon_e.at));
         end
      end
   end

   task automatic issue(input string nm, input logic [1:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] res, input bit push);
      bit sgn, spec, hit;
      int lat;
      sgn  = ~op[0];
      spec = (b == 32'h0) || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
      hit  = CACHE && mvld && ma == a && mb == b && msgn == sgn;
      lat  = (spec || hit) ? 1 : 33;
      @(negedge CLK);
      START  = 1'b1;
      DIV_OP = op;
      DATA1  = a;
      DATA2  = b;
      if (push) begin
         sb.push_back('{res, cyc + lat, nm});
         if (!spec && !hit) begin
            mvld = 1'b1;
            ma   = a;
            mb   = b;
            msgn = sgn;
         end
      end
      #1 chk({nm, "_stall_c0"}, 32'(STALL), 32'd1);
      @(posedge CLK);
      #1 START = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 100; i++) begin
         if (sb.size() == 0) break;
         @(posedge CLK);
         #2;
      end
      chk("drain_pending", 32'(sb.size()), 32'd0);
      sb.delete();
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      RESET  = 1'b1;
      START  = 1'b1;
      FLUSH  = 1'b0;
      DIV_OP = 2'b00;
      DATA1  = 32'd0;
      DATA2  = 32'd0;
      repeat (3) @(posedge CLK);
      #1;
      chk("reset_result", RESULT, 32'h0);
      chk("reset_done", 32'(DONE), 32'd0);
      chk("reset_busy", 32'(BUSY), 32'd0);
      chk("reset_stall", 32'(STALL), 32'd0);
      START = 1'b0;
      @(negedge CLK);
      RESET = 1'b0;

      issue("divu_100_7", 2'b01, 32'd100, 32'd7, 32'd14, 1'b1);
      for (int k = 1; k <= 33; k++) begin
         chk($sformatf("divu_stall_c%0d", k), 32'(STALL), 32'(k <= 32));
         chk($sformatf("divu_busy_c%0d", k), 32'(BUSY), 32'(k <= 32));
         @(posedge CLK);
         #1;
      end
      drain();

      issue("div_m20_3", 2'b00, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFA, 1'b1);
      drain();
      issue("rem_m20_3", 2'b10, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFE, 1'b1);
      drain();
      issue("remu_ffec_3", 2'b11, 32'hFFFF_FFEC, 32'd3, 32'd2, 1'b1);
      drain();
      issue("div_100_m7", 2'b00, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 1'b1);
      drain();
      issue("rem_100_m7", 2'b10, 32'd100, 32'hFFFF_FFF9, 32'd2, 1'b1);
      drain();
      issue("divu_max_1", 2'b01, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 1'b1);
      drain();
      issue("div_7_m100", 2'b00, 32'd7, 32'hFFFF_FF9C, 32'd0, 1'b1);
      drain();
      issue("divu_5_0", 2'b01, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1);
      drain();
      issue("remu_5_0", 2'b11, 32'd5, 32'd0, 32'd5, 1'b1);
      drain();
      issue("rem_m5_0", 2'b10, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 1'b1);
      drain();
      issue("div_min_m1", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
      drain();
      issue("rem_min_m1", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b1);
      drain();
      issue("divu_min_m1", 2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b1);
      drain();

      issue("flushed", 2'b01, 32'd100, 32'd7, 32'd14, 1'b0);
      repeat (9) @(posedge CLK);
      #1;
      FLUSH = 1'b1;
      chk("flush_stall_c10", 32'(STALL), 32'd1);
      @(posedge CLK);
      #1;
      FLUSH = 1'b0;
      chk("flush_stall_c11", 32'(STALL), 32'd0);
      chk("flush_busy_c11", 32'(BUSY), 32'd0);
      issue("divu_after_flush", 2'b01, 32'd100, 32'd7, 32'd14, 1'b1);
      drain();

      issue("b2b_div", 2'b00, 32'd100, 32'd7, 32'd14, 1'b1);
      begin
         bit seen = 1'b0;
         for (int i = 0; i < 40; i++) begin
            @(posedge CLK);
            #1;
            if (DONE) begin
               seen = 1'b1;
               break;
            end
         end
         chk("b2b_done_seen", 32'(seen), 32'd1);
      end
      issue("b2b_rem", 2'b10, 32'd100, 32'd7, 32'd2, 1'b1);
      drain();

      issue("reset_aborted", 2'b01, 32'd100, 32'd7, 32'd14, 1'b0);
      repeat (5) @(posedge CLK);
      #1;
      chk("midrun_busy", 32'(BUSY), 32'd1);
      RESET = 1'b1;
      mvld  = 1'b0;
      @(posedge CLK);
      #1;
      chk("midrun_reset_done", 32'(DONE), 32'd0);
      chk("midrun_reset_busy", 32'(BUSY), 32'd0);
      chk("midrun_reset_stall", 32'(STALL), 32'd0);
      @(negedge CLK);
      RESET = 1'b0;
      issue("rem_after_reset", 2'b10, 32'd100, 32'd7, 32'd2, 1'b1);
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
